sd_cmd_sequencer: RTL and testbench

SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

---
 rtl/sd_cmd_pkg.sv | 32 +++
 rtl/sd_crc_7.sv | 24 ++
 rtl/sd_cmd_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command-line sequencer.
// Holds FSM state encoding, response-type codes, frame lengths and the CRC7 step.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        RECV,
        NWAIT_ST,
        DONE
    } state_t;

    localparam logic [1:0] RESP_NONE   = 2'b00;
    localparam logic [1:0] RESP_48     = 2'b01;
    localparam logic [1:0] RESP_136    = 2'b10;
    localparam logic [1:0] RESP_48_ALT = 2'b11;

    localparam int FRAME_LEN_48  = 48;
    localparam int FRAME_LEN_136 = 136;

    // x^7 + x^3 + 1, x^7 implied by the shift
    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam logic [5:0] R3_INDEX  = 6'h3F;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc_7.sv
// Serial CRC7 register shared by the transmit and receive paths.
// A clear arriving together with an enable folds the first bit into a zero seed.
module sd_crc_7
    import sd_cmd_pkg::*;
(
    input  logic       sd_clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= crc7_step(clr ? 7'h00 : crc, din);
        end else if (clr) begin
            crc <= 7'h00;
        end
    end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD CMD-line sequencer: sends a 48-bit command frame, optionally receives a 48/136-bit response.
// Define SD_CMD_RESP_CRC_CHECK_EN to compile in response CRC checking (crc_err otherwise tied 0).
module sd_cmd_sequencer
    import sd_cmd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64,
    parameter int NWAIT        = 8
) (
    input  logic         sd_clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic         crc_err,
    output logic [127:0] resp,
    output logic [5:0]   resp_index
);

    state_t        state;
    logic [15:0]   cnt;
    logic [38:0]   tx_shift;     // frame bits 1..39, bit 1 at the top
    logic          no_resp;
    logic          long_resp;
    logic [132:0]  rx_shift;
    logic [133:0]  rx_word;
    logic [15:0]   rx_last;
    logic          crc_clr;
    logic          crc_en;
    logic          crc_din;
    logic [6:0]    crc;

    assign rx_word = {rx_shift, cmd_in};
    assign rx_last = long_resp ? 16'(FRAME_LEN_136 - 2) : 16'(FRAME_LEN_48 - 2);

`ifdef SD_CMD_RESP_CRC_CHECK_EN
    logic        crc_err_q;
    logic        rx_crc_bad;
    logic [15:0] rx_crc_first;
    logic [15:0] rx_crc_last;

    // Receive CRC spans bits[47:8] or [127:8]; the leading zero start bit leaves a zero CRC unchanged
    assign rx_crc_first = long_resp ? 16'd7 : 16'd0;
    assign rx_crc_last  = long_resp ? 16'd126 : 16'd38;
    assign crc_err      = crc_err_q;

    always_comb begin
        rx_crc_bad = 1'b0;
        if (!rx_word[0]) begin
            rx_crc_bad = 1'b1;
        end else if (long_resp || rx_word[45:40] != R3_INDEX) begin
            rx_crc_bad = (rx_word[7:1] != crc);
        end
    end
`else
    assign crc_err = 1'b0;
`endif

    // NOTE: every variable gets a default before the branches, so no latch is inferred.
    always_comb begin
        crc_en  = 1'b0;
        crc_din = 1'b0;
        // TX feeds each bit one cycle ahead so the CRC is ready when bit 40 goes out
        if (state == SEND && cnt <= 16'd38) begin
            crc_en  = 1'b1;
            crc_din = tx_shift[38];
        end
`ifdef SD_CMD_RESP_CRC_CHECK_EN
        else if (state == RECV && cnt >= rx_crc_first && cnt <= rx_crc_last) begin
            crc_en  = 1'b1;
            crc_din = cmd_in;
        end
`endif
    end

    sd_crc_7 u_crc (
        .sd_clk (sd_clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .din    (crc_din),
        .crc    (crc)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_shift    <= '0;
            no_resp     <= 1'b0;
            long_resp   <= 1'b0;
            rx_shift    <= '0;
            crc_clr     <= 1'b0;
            cmd_out     <= 1'b1;
            cmd_oe      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            resp        <= '0;
            resp_index  <= '0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
            crc_err_q   <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            crc_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_shift    <= {1'b1, cmd_index, cmd_arg};
                        no_resp     <= (resp_type == RESP_NONE);
                        long_resp   <= (resp_type == RESP_136);
                        timeout_err <= 1'b0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
                        crc_err_q   <= 1'b0;
`endif
                        cmd_out     <= 1'b0;
                        cmd_oe      <= 1'b1;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        crc_clr     <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (cnt == 16'(FRAME_LEN_48 - 1)) begin
                        cmd_out <= 1'b1;
                        cmd_oe  <= 1'b0;
                        cnt     <= '0;
                        state   <= no_resp ? NWAIT_ST : WAIT_RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (cnt == 16'd39) begin
                            // Reload with CRC bits and the end bit; the shift continues without a stall
                            tx_shift <= {crc[5:0], 1'b1, 32'h0};
                            cmd_out  <= crc[6];
                        end else begin
                            tx_shift <= {tx_shift[37:0], 1'b0};
                            cmd_out  <= tx_shift[38];
                        end
                    end
                end
                WAIT_RESP: begin
                    if (!cmd_in) begin
                        cnt   <= '0;
                        state <= RECV;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
                        crc_clr <= 1'b1;
`endif
                    end else if (cnt == 16'(RESP_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= NWAIT_ST;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RECV: begin
                    rx_shift <= rx_word[132:0];
                    if (cnt == rx_last) begin
                        if (long_resp) begin
                            resp_index <= rx_word[133:128];
                            resp       <= rx_word[127:0];
                        end else begin
                            resp_index <= rx_word[45:40];
                            resp       <= {rx_word[39:8], 96'h0};
                        end
`ifdef SD_CMD_RESP_CRC_CHECK_EN
                        crc_err_q <= rx_crc_bad;
`endif
                        cnt   <= '0;
                        state <= NWAIT_ST;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                NWAIT_ST: begin
                    if (cnt == 16'(NWAIT - 1)) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer with a scoreboard of expected per-command results.
// Honours SD_CMD_RESP_CRC_CHECK_EN for the expected crc_err of a corrupted response.
module tb_sd_cmd_sequencer;

    localparam int RESP_TIMEOUT = 64;
    localparam int NWAIT        = 8;

`ifdef SD_CMD_RESP_CRC_CHECK_EN
    localparam logic CRC_CHK = 1'b1;
`else
    localparam logic CRC_CHK = 1'b0;
`endif

    logic         sd_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         cmd_in = 1'b1;
    logic         cmd_out, cmd_oe, busy, done, timeout_err, crc_err;
    logic [127:0] resp;
    logic [5:0]   resp_index;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [47:0]  frame;
        int           nbits;
        int           done_cyc;
        logic         to;
        logic         ce;
        logic [5:0]   ridx;
        logic [127:0] resp;
    } exp_t;

    exp_t sb[$];

    sd_cmd_sequencer #(.RESP_TIMEOUT(RESP_TIMEOUT), .NWAIT(NWAIT)) dut (
        .sd_clk      (sd_clk),
        .rst_n       (rst_n),
        .start       (start),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .resp_type   (resp_type),
        .cmd_in      (cmd_in),
        .cmd_out     (cmd_out),
        .cmd_oe      (cmd_oe),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .crc_err     (crc_err),
        .resp        (resp),
        .resp_index  (resp_index)
    );

    always #5 sd_clk = ~sd_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7_of(input logic [135:0] v, input int hi, input int lo);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = hi; i >= lo; i--) begin
            fb = c[6] ^ v[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [47:0] f;
        f        = '0;
        f[47:8]  = {2'b01, idx, arg};
        f[7:1]   = crc7_of({88'h0, f}, 47, 8);
        f[0]     = 1'b1;
        return f;
    endfunction

    function automatic exp_t mk_exp(input logic [47:0] frame, input int nbits, input int done_cyc,
                                    input logic to, input logic ce, input logic [5:0] ridx,
                                    input logic [127:0] rsp);
        exp_t e;
        e.frame = frame; e.nbits = nbits; e.done_cyc = done_cyc;
        e.to = to; e.ce = ce; e.ridx = ridx; e.resp = rsp;
        return e;
    endfunction

    // Issue one command, capture the frame, play a response from cycle 50 on, then score it.
    // Cycle 0 is the cycle after the edge that accepts start.
    task automatic do_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [1:0] rt, input logic [135:0] rsp, input int rsp_len,
                          input logic poke, input exp_t e);
        exp_t        want;
        logic [47:0] frame;
        int          nbits, done_cyc, ndone;
        logic        busy_at0, busy_after;
        frame = '0; nbits = 0; done_cyc = -1; ndone = 0;
        busy_at0 = 1'b0; busy_after = 1'b1;
        sb.push_back(e);
        @(negedge sd_clk);
        start = 1'b1; cmd_index = idx; cmd_arg = arg; resp_type = rt;
        @(posedge sd_clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge sd_clk);
            if (cyc == 0) busy_at0 = busy;
            if (cmd_oe) begin
                frame = {frame[46:0], cmd_out};
                nbits++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            start = poke && (cyc == 10 || (done_cyc >= 0 && cyc == done_cyc));
            if (start) begin
                cmd_index = ~idx; cmd_arg = ~arg; resp_type = ~rt;
            end
            cmd_in = (cyc >= 50 && cyc < 50 + rsp_len) ? rsp[rsp_len - 1 - (cyc - 50)] : 1'b1;
            if (done_cyc >= 0 && cyc == done_cyc + 4) break;
        end
        start  = 1'b0;
        cmd_in = 1'b1;
        want = sb.pop_front();
        check({tag, " busy_start"}, 128'(busy_at0), 128'(1'b1));
        check({tag, " frame"}, 128'(frame), 128'(want.frame));
        check({tag, " frame_bits"}, 128'(nbits), 128'(want.nbits));
        check({tag, " done_cycle"}, 128'(done_cyc), 128'(want.done_cyc));
        check({tag, " done_count"}, 128'(ndone), 128'(1));
        check({tag, " busy_after"}, 128'(busy_after), 128'(1'b0));
        check({tag, " timeout_err"}, 128'(timeout_err), 128'(want.to));
        check({tag, " crc_err"}, 128'(crc_err), 128'(want.ce));
        check({tag, " resp_index"}, 128'(resp_index), 128'(want.ridx));
        check({tag, " resp"}, resp, want.resp);
    endtask

    initial begin
        logic [135:0] r2;
        logic [5:0]   r2_idx;

        repeat (3) @(negedge sd_clk);
        check("rst cmd_out", 128'(cmd_out), 128'(1'b1));
        check("rst cmd_oe", 128'(cmd_oe), 128'(1'b0));
        check("rst busy", 128'(busy), 128'(1'b0));
        check("rst done", 128'(done), 128'(1'b0));
        check("rst timeout_err", 128'(timeout_err), 128'(1'b0));
        check("rst crc_err", 128'(crc_err), 128'(1'b0));
        check("rst resp", resp, 128'h0);
        check("rst resp_index", 128'(resp_index), 128'h0);
        rst_n = 1'b1;
        @(negedge sd_clk);

        // CMD0, no response: 48 frame + NWAIT idle cycles before done
        do_cmd("cmd0", 6'd0, 32'h0, 2'b00, '0, 0, 1'b0,
               mk_exp(48'h400000000095, 48, 48 + NWAIT, 1'b0, 1'b0, 6'h00, 128'h0));

        // CMD8 with a good R7: start bit sampled at edge 51, 47 more bits, then NWAIT
        do_cmd("cmd8", 6'd8, 32'h000001AA, 2'b01, 136'h08000001AA13, 48, 1'b0,
               mk_exp(48'h48000001AA87, 48, 50 + 48 + NWAIT, 1'b0, 1'b0, 6'h08,
                      {32'h000001AA, 96'h0}));

        do_cmd("cmd8_badcrc", 6'd8, 32'h000001AA, 2'b01, 136'h08000001AA15, 48, 1'b0,
               mk_exp(48'h48000001AA87, 48, 50 + 48 + NWAIT, 1'b0, CRC_CHK, 6'h08,
                      {32'h000001AA, 96'h0}));

        // No response: 64 WAIT_RESP cycles, then NWAIT; previous resp fields are held
        do_cmd("timeout", 6'd55, 32'h0, 2'b01, '0, 0, 1'b0,
               mk_exp(make_frame(6'd55, 32'h0), 48, 48 + RESP_TIMEOUT + NWAIT, 1'b1, 1'b0,
                      6'h08, {32'h000001AA, 96'h0}));

        // Reset in the middle of a frame
        @(negedge sd_clk);
        start = 1'b1; cmd_index = 6'd17; cmd_arg = 32'h00001234; resp_type = 2'b01;
        @(posedge sd_clk);
        @(negedge sd_clk);
        start = 1'b0;
        repeat (20) @(negedge sd_clk);
        check("midrst oe_before", 128'(cmd_oe), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        check("midrst cmd_oe", 128'(cmd_oe), 128'(1'b0));
        check("midrst busy", 128'(busy), 128'(1'b0));
        check("midrst cmd_out", 128'(cmd_out), 128'(1'b1));
        check("midrst resp_index", 128'(resp_index), 128'h0);
        @(negedge sd_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sd_clk);
        check("midrst idle_oe", 128'(cmd_oe), 128'(1'b0));

        do_cmd("after_rst", 6'd8, 32'h000001AA, 2'b01, 136'h08000001AA13, 48, 1'b0,
               mk_exp(48'h48000001AA87, 48, 50 + 48 + NWAIT, 1'b0, 1'b0, 6'h08,
                      {32'h000001AA, 96'h0}));

        // R2: 136-bit response with a valid CRC over bits[127:8]
        r2_idx         = 6'h3F;
        r2             = '0;
        r2[135:128]    = {2'b00, r2_idx};
        r2[127:8]      = 120'h03534453443332801234567800A2B3;
        r2[7:1]        = crc7_of(r2, 127, 8);
        r2[0]          = 1'b1;
        do_cmd("r2", 6'd2, 32'h0, 2'b10, r2, 136, 1'b0,
               mk_exp(make_frame(6'd2, 32'h0), 48, 50 + 136 + NWAIT, 1'b0, 1'b0, r2_idx,
                      r2[127:0]));

        // R3 via resp_type 11, CRC field all ones (exempt); start poked in SEND and DONE
        do_cmd("r3_poke", 6'd41, 32'h40FF8000, 2'b11, 136'h3F00FF8000FF, 48, 1'b1,
               mk_exp(make_frame(6'd41, 32'h40FF8000), 48, 50 + 48 + NWAIT, 1'b0, 1'b0,
                      6'h3F, {32'h00FF8000, 96'h0}));

        repeat (4) @(negedge sd_clk);
        check("final idle busy", 128'(busy), 128'(1'b0));
        check("final idle oe", 128'(cmd_oe), 128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
